// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle of uart_rx_param: payload, status flags and valid/ready.
// master = receiver that presents frames, slave = consumer that accepts them.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output data,
      output valid,
      output frame_err,
      output parity_err,
      output overrun,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  frame_err,
      input  parity_err,
      input  overrun,
      output ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output and frame/parity/overrun status.
// Optional: define UART_RX_MAJORITY_EN to take every bit as a 3-sample majority around mid-bit.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick_i,
   input  logic            in_i,
   output logic            busy_o,
   uart_rx_param_if.master rx_if
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(OVERSAMPLE / 2);
`else
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
`endif
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);
   localparam logic             PARITY_ODD = (PARITY == 1);
   localparam logic             PARITY_ON  = (PARITY != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   // Line synchroniser and tick-rate edge history
   logic sync1_q, sync_q;
   logic s_prev_q, s_prev_d;

   // Receive FSM and datapath
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 done;

   // Output holding registers
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
   logic                 accept;

   logic [CNT_W-1:0]     last_cnt;
   logic                 at_sample;
   logic                 bit_val;

   assign last_cnt  = (state_q == S_START) ? START_LAST : BIT_LAST;
   assign at_sample = (cnt_q == last_cnt);
   assign s_prev_d  = tick_i ? sync_q : s_prev_q;

`ifdef UART_RX_MAJORITY_EN
   // The two early votes are captured on the ticks just before the decision tick
   logic [1:0] vote_q, vote_d;

   always_comb begin
      vote_d = vote_q;
      if (tick_i && (cnt_q == last_cnt - CNT_W'(2))) vote_d[0] = sync_q;
      if (tick_i && (cnt_q == last_cnt - CNT_W'(1))) vote_d[1] = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vote_q <= 2'b11;
      else     vote_q <= vote_d;
   end

   assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync_q) | (vote_q[1] & sync_q);
`else
   assign bit_val = sync_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync_q   <= 1'b1;
         s_prev_q <= 1'b1;
         state_q  <= S_IDLE;
      end else begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
         sync1_q  <= in_i;
         sync_q   <= sync1_q;
         s_prev_q <= s_prev_d;
         state_q  <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path can leave one unassigned (latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      done    = 1'b0;

      if (tick_i) begin
         if (state_q != S_IDLE) cnt_d = at_sample ? '0 : cnt_q + 1'b1;

         unique case (state_q)
            S_IDLE: begin
               if (!sync_q && s_prev_q) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end
            S_START: begin
               if (at_sample) begin
                  if (bit_val) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     idx_d   = '0;
                  end
               end
            end
            S_DATA: begin
               if (at_sample) begin
                  shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                  if (idx_q == DATA_LAST) begin
                     idx_d   = '0;
                     ferr_d  = 1'b0;
                     perr_d  = 1'b0;
                     state_d = PARITY_ON ? S_PARITY : S_STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (at_sample) begin
                  perr_d  = ((^shift_q) ^ bit_val) != PARITY_ODD;
                  state_d = S_STOP;
               end
            end
            S_STOP: begin
               if (at_sample) begin
                  if (!bit_val) ferr_d = 1'b1;
                  if (idx_q == STOP_LAST) begin
                     state_d = S_IDLE;
                     done    = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A completing frame either replaces an empty/accepted slot or is dropped as an overrun
   always_comb begin
      accept       = valid_q && rx_if.ready;
      valid_d      = valid_q && !accept;
      data_d       = data_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;

      if (done) begin
         if (!valid_q || accept) begin
            valid_d      = 1'b1;
            data_d       = shift_q;
            frame_err_d  = ferr_d;
            parity_err_d = perr_q;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         ferr_q       <= 1'b0;
         perr_q       <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         ferr_q       <= ferr_d;
         perr_q       <= perr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_if.data       = data_q;
   assign rx_if.valid      = valid_q;
   assign rx_if.frame_err  = frame_err_q;
   assign rx_if.parity_err = parity_err_q;
   assign rx_if.overrun    = overrun_q;
   assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: dut0 (8N1) and dut2 (8E2) on separate serial lines.
// Frames are pushed to per-DUT queues as sent; negedge monitors pop on each new presentation.
module tb_uart_rx_param;
   localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   // Tick index (from the tick before the start bit) of the last stop sample
   localparam int LAST0 = 1 + OS / 2 + OS * 9 + MAJ;
   localparam int LAST2 = 1 + OS / 2 + OS * 11 + MAJ;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic       ov;
   } exp_t;

   logic clk, rst, tick, rx0, rx2, busy0, busy2, was_tick;
   int   cyc;
   int   n_tests, n_fail;
   bit   pres0, pres2;
   exp_t exp_q0[$];
   exp_t exp_q2[$];

   uart_rx_param_if #(.DATA_BITS(8)) rx0_if ();
   uart_rx_param_if #(.DATA_BITS(8)) rx2_if ();

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .tick_i(tick), .in_i(rx0), .busy_o(busy0), .rx_if(rx0_if)
   );

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .tick_i(tick), .in_i(rx2), .busy_o(busy2), .rx_if(rx2_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expect_frame(input int which, input logic [7:0] d, input logic fe, input logic pe,
                               input logic ov);
      exp_t e;
      e.data = d; e.fe = fe; e.pe = pe; e.ov = ov;
      if (which == 0) exp_q0.push_back(e);
      else            exp_q2.push_back(e);
   endtask

   task automatic score(input int which, input logic [7:0] d, input logic fe, input logic pe,
                        input logic ov);
      exp_t e;
      if ((which == 0 && exp_q0.size() == 0) || (which != 0 && exp_q2.size() == 0)) begin
         n_tests++;
         n_fail++;
         $display("FAIL dut%0d unexpected frame: got data %0h, required no frame", which, d);
         return;
      end
      if (which == 0) e = exp_q0.pop_front();
      else            e = exp_q2.pop_front();
      check($sformatf("dut%0d data", which), 32'(d), 32'(e.data));
      check($sformatf("dut%0d frame_err", which), 32'(fe), 32'(e.fe));
      check($sformatf("dut%0d parity_err", which), 32'(pe), 32'(e.pe));
      check($sformatf("dut%0d overrun", which), 32'(ov), 32'(e.ov));
   endtask

   // Monitors: a presentation is new when valid is seen and no unaccepted frame was showing
   always @(negedge clk) begin
      if (rx0_if.valid && !pres0) begin
         pres0 = 1'b1;
         score(0, rx0_if.data, rx0_if.frame_err, rx0_if.parity_err, rx0_if.overrun);
      end
      if (!rx0_if.valid || rx0_if.ready) pres0 = 1'b0;
   end

   always @(negedge clk) begin
      if (rx2_if.valid && !pres2) begin
         pres2 = 1'b1;
         score(2, rx2_if.data, rx2_if.frame_err, rx2_if.parity_err, rx2_if.overrun);
      end
      if (!rx2_if.valid || rx2_if.ready) pres2 = 1'b0;
   end

   task automatic step();
      @(posedge clk);
      #1;
      was_tick = tick;
      cyc++;
      tick = (cyc % 4 == 0);
   endtask

   task automatic next_tick();
      do step(); while (!was_tick);
   endtask

   task automatic idle(input int n);
      repeat (n) next_tick();
   endtask

   task automatic drive(input int which, input logic v);
      if (which == 0) rx0 = v;
      else            rx2 = v;
   endtask

   task automatic set_ready(input int which, input logic v);
      if (which == 0) rx0_if.ready = v;
      else            rx2_if.ready = v;
   endtask

   task automatic accept(input int which);
      set_ready(which, 1'b1);
      step();
      set_ready(which, 1'b0);
   endtask

   // Sends one frame starting right after a tick edge; optional ready pulse, reset abort, spike
   task automatic send(input int which, input logic [7:0] d, input logic pbit, input logic [1:0] stops,
                       input int pulse_at, input int abort_at, input int spike_at);
      logic [11:0] bits;
      int          nbits;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      if (which == 0) begin
         nbits   = 10;
         bits[9] = stops[0];
      end else begin
         nbits    = 12;
         bits[9]  = pbit;
         bits[10] = stops[0];
         bits[11] = stops[1];
      end
      for (int k = 0; k < nbits * OS; k++) begin
         logic v;
         v = bits[k / OS];
         if (k == spike_at) v = ~v;
         drive(which, v);
         if (k == abort_at) begin
            check("busy mid-data", 32'(busy0), 32'd1);
            rst = 1'b1;
            #1;
            check("reset data", 32'(rx0_if.data), 32'h0);
            check("reset valid", 32'(rx0_if.valid), 32'd0);
            check("reset overrun", 32'(rx0_if.overrun), 32'd0);
            check("reset frame_err", 32'(rx0_if.frame_err), 32'd0);
            check("reset busy", 32'(busy0), 32'd0);
            step();
            rst = 1'b0;
            break;
         end
         if (k == pulse_at) begin
            repeat (3) step();
            set_ready(which, 1'b1);
            step();
            set_ready(which, 1'b0);
         end else begin
            next_tick();
         end
      end
      drive(which, 1'b1);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; was_tick = 1'b0;
      pres0 = 1'b0; pres2 = 1'b0;
      rst = 1'b1; tick = 1'b0; rx0 = 1'b1; rx2 = 1'b1;
      rx0_if.ready = 1'b0; rx2_if.ready = 1'b0;
      repeat (3) step();
      check("init valid0", 32'(rx0_if.valid), 32'd0);
      check("init data0", 32'(rx0_if.data), 32'h0);
      check("init busy0", 32'(busy0), 32'd0);
      check("init overrun0", 32'(rx0_if.overrun), 32'd0);
      check("init valid2", 32'(rx2_if.valid), 32'd0);
      check("init busy2", 32'(busy2), 32'd0);
      rst = 1'b0;
      idle(4);

      // Nominal 8N1 frame, then accept
      expect_frame(0, 8'h61, 1'b0, 1'b0, 1'b0);
      send(0, 8'h61, 1'b0, 2'b11, -1, -1, -1);
      check("nominal valid", 32'(rx0_if.valid), 32'd1);
      check("nominal data", 32'(rx0_if.data), 32'h61);
      accept(0);
      check("valid drops after accept", 32'(rx0_if.valid), 32'd0);
      idle(2);

      // Even parity: good, bad, then second stop bit low
      expect_frame(2, 8'h61, 1'b0, 1'b0, 1'b0);
      send(2, 8'h61, 1'b1, 2'b11, -1, -1, -1);
      check("parity ok flag", 32'(rx2_if.parity_err), 32'd0);
      accept(2);
      idle(2);
      expect_frame(2, 8'h61, 1'b0, 1'b1, 1'b0);
      send(2, 8'h61, 1'b0, 2'b11, -1, -1, -1);
      check("parity bad flag", 32'(rx2_if.parity_err), 32'd1);
      accept(2);
      idle(2);
      expect_frame(2, 8'hA5, 1'b1, 1'b0, 1'b0);
      send(2, 8'hA5, 1'b0, 2'b01, -1, -1, -1);
      check("second stop low", 32'(rx2_if.frame_err), 32'd1);
      accept(2);
      idle(2);

      // Stop bit low on 8N1
      expect_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0);
      send(0, 8'h3C, 1'b0, 2'b00, -1, -1, -1);
      check("stop low frame_err", 32'(rx0_if.frame_err), 32'd1);
      accept(0);
      idle(4);

      // Two-tick glitch on the idle line is rejected as a false start
      rx0 = 1'b0;
      next_tick();
      next_tick();
      rx0 = 1'b1;
      idle(2);
      check("glitch enters start", 32'(busy0), 32'd1);
      idle(10);
      check("glitch back to idle", 32'(busy0), 32'd0);
      check("glitch no valid", 32'(rx0_if.valid), 32'd0);

      // Ready pulsed exactly on the completion cycle of a second frame
      expect_frame(0, 8'h2A, 1'b0, 1'b0, 1'b0);
      send(0, 8'h2A, 1'b0, 2'b11, -1, -1, -1);
      expect_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
      send(0, 8'h55, 1'b0, 2'b11, LAST0 - 1, -1, -1);
      check("same-cycle valid", 32'(rx0_if.valid), 32'd1);
      check("same-cycle data", 32'(rx0_if.data), 32'h55);
      check("same-cycle overrun", 32'(rx0_if.overrun), 32'd0);
      accept(0);
      idle(2);

      // Overrun: second frame lost while the first is held
      expect_frame(0, 8'h41, 1'b0, 1'b0, 1'b0);
      send(0, 8'h41, 1'b0, 2'b11, -1, -1, -1);
      send(0, 8'h42, 1'b0, 2'b11, -1, -1, -1);
      check("overrun data held", 32'(rx0_if.data), 32'h41);
      check("overrun valid held", 32'(rx0_if.valid), 32'd1);
      check("overrun set", 32'(rx0_if.overrun), 32'd1);
      accept(0);
      check("overrun accept valid", 32'(rx0_if.valid), 32'd0);
      check("overrun sticky", 32'(rx0_if.overrun), 32'd1);
      idle(2);

      // Reset in the middle of the data bits, then a clean frame
      send(0, 8'h33, 1'b0, 2'b11, -1, 40, -1);
      idle(4);
      expect_frame(0, 8'h33, 1'b0, 1'b0, 1'b0);
      send(0, 8'h33, 1'b0, 2'b11, -1, -1, -1);
      check("post-reset data", 32'(rx0_if.data), 32'h33);
      accept(0);
      idle(2);

`ifdef UART_RX_MAJORITY_EN
      // One-sample spike at mid-bit of bit 0 is outvoted
      expect_frame(0, 8'h33, 1'b0, 1'b0, 1'b0);
      send(0, 8'h33, 1'b0, 2'b11, -1, -1, OS + OS / 2);
      check("majority data", 32'(rx0_if.data), 32'h33);
      accept(0);
      idle(2);
`endif

      idle(4);
      check("dut0 frames outstanding", 32'(exp_q0.size()), 32'd0);
      check("dut2 frames outstanding", 32'(exp_q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
